// File: rtl/addr_bus_mux_pkg.sv
// addr_bus_mux_pkg: shared address-bus widths and source-select encodings
package addr_bus_mux_pkg;
  localparam int PC_W = 8;
  localparam int ADDR_W = 16;
  localparam logic SEL_PC = 1'b0;
  localparam logic SEL_DATA = 1'b1;
endpackage

// File: rtl/addr_bus_if.sv
// addr_bus_if: source inputs and registered address outputs of the bus mux
interface addr_bus_if import addr_bus_mux_pkg::*; #(
  parameter int PC_W = addr_bus_mux_pkg::PC_W,
  parameter int ADDR_W = addr_bus_mux_pkg::ADDR_W
);
  logic select;
  logic [PC_W-1:0] pc_address;
  logic [ADDR_W-1:0] addr_bus_data_access;
  logic [ADDR_W-1:0] address_bus;
  logic bus_src;
  logic addr_valid;
  modport master (
    output select, pc_address, addr_bus_data_access,
    input address_bus, bus_src, addr_valid
  );
  modport slave (
    input select, pc_address, addr_bus_data_access,
    output address_bus, bus_src, addr_valid
  );
endinterface

// File: rtl/addr_bus_reg.sv
// addr_bus_reg: width-parameterised register with asynchronous active-low clear
module addr_bus_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= '0;
    else q <= d;
endmodule

// File: rtl/addr_bus_mux.sv
// addr_bus_mux: registered selection of PC or data-access address onto the memory bus
module addr_bus_mux import addr_bus_mux_pkg::*; #(
  parameter int PC_W = addr_bus_mux_pkg::PC_W,
  parameter int ADDR_W = addr_bus_mux_pkg::ADDR_W
) (
  input logic       clk,
  input logic       reset_n,
  addr_bus_if.slave bus
);
  logic [ADDR_W-1:0] nxt;
  logic [ADDR_W+1:0] q;
  // An unknown select yields an unknown nxt and bus_src rather than picking a side
  assign nxt = (bus.select == SEL_DATA) ? bus.addr_bus_data_access : ADDR_W'(bus.pc_address);
  addr_bus_reg #(.W(ADDR_W + 2)) u_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({nxt, bus.select, 1'b1}),
    .q       (q)
  );
  assign {bus.address_bus, bus.bus_src, bus.addr_valid} = q;
endmodule

// File: tb/tb_addr_bus_mux.sv
// tb_addr_bus_mux: randomized and directed checks of addr_bus_mux against a behavioural model
module tb_addr_bus_mux;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_addr = '0;
  logic exp_src = 1'b0;
  logic exp_valid = 1'b0;
  addr_bus_if #(.PC_W(8), .ADDR_W(16)) bus ();
  addr_bus_mux #(.PC_W(8), .ADDR_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, ".addr"}, bus.address_bus, exp_addr);
    check({tag, ".src"}, 16'(bus.bus_src), 16'(exp_src));
    check({tag, ".valid"}, 16'(bus.addr_valid), 16'(exp_valid));
  endtask
  task automatic drive(input logic s, input logic [7:0] p, input logic [15:0] d);
    bus.select = s;
    bus.pc_address = p;
    bus.addr_bus_data_access = d;
  endtask
  // One clock edge: the model latches the source chosen by select, PC zero-extended
  task automatic step(input string tag, input logic s, input logic [7:0] p, input logic [15:0] d);
    drive(s, p, d);
    @(posedge clk);
    if (reset_n) begin
      exp_addr = s ? d : 16'(int'(p));
      exp_src = s;
      exp_valid = 1'b1;
    end
    #1;
    check_all(tag);
  endtask
  initial begin
    drive(1'b1, 8'd1, 16'd200);
    #1;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;
    step("pc_path", 1'b0, 8'd1, 16'd200);
    check("pc_path.lit", bus.address_bus, 16'd1);
    step("data_path", 1'b1, 8'd1, 16'd200);
    check("data_path.lit", bus.address_bus, 16'b0000000011001000);
    step("pc_max", 1'b0, 8'hFF, 16'h1234);
    check("pc_max.lit", bus.address_bus, 16'h00FF);
    step("data_max", 1'b1, 8'h00, 16'hFFFF);
    check("data_max.lit", bus.address_bus, 16'hFFFF);
    for (int i = 0; i < 8; i++) begin
      step("toggle", 1'(i % 2), 8'h12, 16'hABCD);
      check("toggle.lit", bus.address_bus, (i % 2) ? 16'hABCD : 16'h0012);
    end
    // Inputs changed between edges must not reach the bus before the next edge
    drive(1'b0, 8'h5A, 16'h0F0F);
    #2;
    drive(1'b1, 8'hA5, 16'hF0F0);
    #1;
    check_all("between_edges");
    step("after_change", 1'b1, 8'hA5, 16'hF0F0);
    #1;
    reset_n = 1'b0;
    #1;
    exp_addr = '0;
    exp_src = 1'b0;
    exp_valid = 1'b0;
    check_all("mid_reset");
    @(posedge clk);
    #1;
    check_all("held_reset");
    @(negedge clk);
    reset_n = 1'b1;
    step("post_release", 1'b0, 8'h77, 16'h9999);
    for (int i = 0; i < 200; i++) begin
      logic s;
      logic [7:0] p;
      logic [15:0] d;
      s = 1'($urandom_range(0, 1));
      p = 8'($urandom);
      d = 16'($urandom);
      step("random", s, p, d);
      if ($urandom_range(0, 19) == 0) begin
        #2;
        drive(~s, 8'($urandom), 16'($urandom));
        #1;
        check_all("random_between");
      end
      if ($urandom_range(0, 39) == 0) begin
        reset_n = 1'b0;
        exp_addr = '0;
        exp_src = 1'b0;
        exp_valid = 1'b0;
        #1;
        check_all("random_reset");
        @(negedge clk);
        reset_n = 1'b1;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
